// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_PRESCALE_WIDTH = 6;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_baud_counter.sv
// Per-bit cycle counter and DATA bit index for the UART transmitter.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   enable       count cycles of the current bit (frame in progress)
//   clear        restart counter and index (new frame accepted)
//   data_phase   bit index advances on bit_done_c only while high
//   p            cycles per bit, must be >= 1
//   bit_done_c   combinational pulse on the last cycle of each bit
//   bit_idx      index of the data bit currently on the line
module tx_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH,
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      data_phase,
  input  logic [PRESCALE_WIDTH-1:0] p,
  output logic                      bit_done_c,
  output logic [IDX_W-1:0]          bit_idx
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic                      last_idx_c;

  // Counter wraps at p-1, so it can never overflow its width.
  assign bit_done_c = enable && (cnt_q == (p - PRESCALE_WIDTH'(1)));
  assign last_idx_c = (bit_idx == IDX_W'(DATA_WIDTH - 1));

  // Cycle counter and bit index.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt_q   <= '0;
      bit_idx <= '0;
    end else if (bit_done_c) begin
      cnt_q <= '0;
      if (data_phase) begin
        bit_idx <= last_idx_c ? '0 : bit_idx + IDX_W'(1);
      end
    end else if (enable) begin
      cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit; each bit held for max(prescale,1) CLK cycles.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   P_DATA      byte to send, latched on acceptance
//   Data_Valid  request, accepted only while idle
//   PAR_EN      insert parity bit
//   PAR_TYP     0 = even, 1 = odd parity
//   prescale    CLK cycles per bit (0 treated as 1)
//   TX_OUT      registered serial line, idle high
//   Busy        registered, high for the whole frame
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;

  logic                      tx_d;
  logic                      busy_d;
  logic                      load_c;
  logic                      bit_done_c;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          idx_next_c;
  logic                      last_bit_c;
  logic                      parity_c;
  logic [PRESCALE_WIDTH-1:0] p_eff_c;

  assign p_eff_c    = (prescale_q == '0) ? PRESCALE_WIDTH'(1) : prescale_q;
  assign parity_c   = (^data_q) ^ par_typ_q;
  assign idx_next_c = bit_idx + IDX_W'(1);
  assign last_bit_c = (bit_idx == IDX_W'(DATA_WIDTH - 1));

  tx_baud_counter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_baud (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (state_q != IDLE),
    .clear      (load_c),
    .data_phase (state_q == DATA),
    .p          (p_eff_c),
    .bit_done_c (bit_done_c),
    .bit_idx    (bit_idx)
  );

  // Next state plus the line level and busy flag for the next cycle.
  always_comb begin
    state_d = state_q;
    tx_d    = IDLE_LEVEL;
    load_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          load_c  = 1'b1;
          state_d = START;
          tx_d    = START_BIT;
        end
      end
      START: begin
        tx_d = START_BIT;
        if (bit_done_c) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        tx_d = data_q[bit_idx];
        if (bit_done_c) begin
          if (!last_bit_c) begin
            tx_d = data_q[idx_next_c];
          end else if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity_c;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end
        end
      end
      PARITY: begin
        tx_d = parity_c;
        if (bit_done_c) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
      STOP: begin
        tx_d = STOP_BIT;
        if (bit_done_c) begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      TX_OUT  <= IDLE_LEVEL;
      Busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      TX_OUT  <= tx_d;
      Busy    <= busy_d;
    end
  end

  // Frame settings captured at acceptance; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
    end else if (load_c) begin
      data_q     <= P_DATA;
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
      prescale_q <= prescale;
    end
  end

endmodule
